data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the 5-stage RV32I core: the memory-side end of the LSU data request interface. It advertises grant, accepts one load or store per handshake and performs byte-enabled writes into an internal word array. Each accepted request returns exactly one response (read data or error) after a fixed, parameterised latency. It sits between the memory stage and the data SRAM, replacing the ideal always-ready memory model.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, at least 2.
- `LATENCY`, 2: cycles from the accept edge to the edge that samples the response; 1 to 15.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_addr_valid_i`  in  1  request valid; a request is accepted on a rising edge where valid && `data_gnt_o`.
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_be_i`  in  4  store byte-lane enables; bit n selects bits [8n+7:8n]; ignored for loads.
- `data_addr_i`  in  32  byte address.
- `data_wdata_i`  in  32  store data, lane-aligned.
- `data_gnt_o`  out  1  responder can accept a request this cycle.
- `data_rvalid_o`  out  1  one-cycle response strobe.
- `data_rdata_o`  out  32  load data, full word; valid only while `data_rvalid_o`=1.
- `data_err_o`  out  1  the response is an error; valid only while `data_rvalid_o`=1.

## Operation
- States:
  - IDLE: `data_gnt_o`=1.
  - BUSY: `data_gnt_o`=0; a down-counter runs.
  - RESP: `data_gnt_o`=0; `data_rvalid_o`=1.
- Accept in IDLE:
  - Latch `data_we_i`, word index `data_addr_i[31:2]`, and the error flag.
  - LATENCY=1: go directly to RESP.
  - Otherwise: load the counter with LATENCY-1 and go to BUSY.
- BUSY: decrement each cycle; at count 1, go to RESP.
- RESP: lasts one cycle, then returns to IDLE unconditionally.
- Error condition: `data_addr_i[1:0]`≠0, or word index ≥ `DEPTH_WORDS`.
- Store, no error:
  - Write the enabled lanes at the accept edge; disabled lanes are unchanged.
  - Response: `data_rdata_o`=0, `data_err_o`=0.
- Load, no error:
  - Read the word at the accept edge and hold it in the response register.
  - A store accepted earlier is always visible to a later load.
- Any error:
  - No array write.
  - Response: `data_rdata_o`=0, `data_err_o`=1.
- Requests while `data_gnt_o`=0 are ignored with no side effects. The requester must hold valid until granted.
- Array contents are not reset and are X after power-up.

## Timing
- While `reset`=0: state IDLE, counter 0; `data_gnt_o`=0, `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0.
- `data_gnt_o` = (state==IDLE) && `reset`. It rises in the cycle reset deasserts.
- Response timing:
  - Accept at edge k; `data_rvalid_o` is high in the cycle between edges k+LATENCY-1 and k+LATENCY.
  - The requester samples the response at edge k+LATENCY.
- Throughput: one request per LATENCY+1 cycles. `data_gnt_o` is low from edge k to edge k+LATENCY.
- Grant is independent of `data_addr_valid_i`; there is no combinational path from valid to grant.
- Reset asserted mid-BUSY or mid-RESP:
  - Outputs go to reset values immediately.
  - The pending response is dropped.
  - A store already written at the accept edge stays in the array.
- Counter width is 4 bits. `LATENCY` outside 1..15 is a compile-time error.

## Configuration
- `DMEM_ERR_CHECK_EN` defined:
  - Error detection as in Operation.
  - `data_err_o` is driven.
  - Erroneous requests never write.
- Not defined:
  - `data_err_o` is tied 0.
  - `data_addr_i[1:0]` is ignored.
  - The word index wraps modulo `DEPTH_WORDS` (upper bits dropped).
  - Every request is performed and returns normally.

## Test plan
- Store then load: store 0xDEADBEEF to 0x10 with be=4'b1111, then load 0x10 -> second response has rdata=0xDEADBEEF, err=0; rvalid exactly one cycle at edge k+2 (LATENCY=2).
- Partial store: word 0x20 holds 0x11223344; store be=4'b0101, wdata=0xAABBCCDD -> load 0x20 returns 0x11BB33DD.
- Latency and grant: LATENCY=4, load accepted at edge 10 -> rvalid sampled at edge 14; gnt=0 from edge 10 to 14; a valid held from edge 11 is accepted at edge 15.
- Errors with macro: load 0x22 -> err=1, rdata=0. Store to word DEPTH_WORDS -> err=1 and word 0 unchanged. Without the macro, the same store overwrites word 0 and err=0.
- Reset mid-BUSY: LATENCY=3, reset pulsed low one cycle after accept -> rvalid never asserts; gnt=0 during reset, 1 the cycle after release; a subsequent load is served normally.
- Back-to-back valid: valid held high continuously for 3 loads -> exactly 3 responses, spaced LATENCY+1 cycles apart, data in request order.

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-side responder for the LSU data port: byte-enabled word array, one response per request after LATENCY cycles.
// Define DMEM_ERR_CHECK_EN to report misaligned or out-of-range accesses as errors instead of wrapping.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_addr_valid_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 1..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("data_mem_responder: DEPTH_WORDS must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         count;
  logic [3:0]         count_next;
  logic               gnt;
  logic               accept;
  logic               req_err;
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [DEPTH_WORDS];

  // Grant is qualified by reset so it rises in the same cycle reset is released.
  assign gnt      = (state == IDLE) && reset;
  assign accept   = data_addr_valid_i && gnt;
  assign word_idx = data_addr_i[IDX_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (data_addr_i[1:0] != 2'b00) ||
                   ({2'b00, data_addr_i[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0]};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = LAT_M1;
          end
        end
      end
      BUSY: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // The array is deliberately not reset; stores land at the accept edge.
  always_ff @(posedge clock) begin
    if (accept && data_we_i && !req_err) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (data_be_i[lane]) begin
          mem[word_idx][8*lane +: 8] <= data_wdata_i[8*lane +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (!data_we_i && !req_err) ? mem[word_idx] : 32'd0;
      err_q   <= req_err;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = (state == RESP);
  assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'd0;

`ifdef DMEM_ERR_CHECK_EN
  assign data_err_o = data_rvalid_o && err_q;
`else
  logic unused_err_q;
  assign unused_err_q = err_q;
  assign data_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clock;
  logic        reset;
  logic        data_addr_valid_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .data_addr_valid_i(data_addr_valid_i),
    .data_we_i        (data_we_i),
    .data_be_i        (data_be_i),
    .data_addr_i      (data_addr_i),
    .data_wdata_i     (data_wdata_i),
    .data_gnt_o       (data_gnt_o),
    .data_rvalid_o    (data_rvalid_o),
    .data_rdata_o     (data_rdata_o),
    .data_err_o       (data_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: plain word array, error rule and wrap rule straight from the address arithmetic.
  function automatic void model_apply(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                      input logic [31:0] wdata, output logic [31:0] rdata,
                                      output logic err);
    int unsigned word;
    word = addr / 4;
`ifdef DMEM_ERR_CHECK_EN
    err = (addr % 4 != 0) || (word >= DEPTH);
`else
    err  = 1'b0;
    word = word % DEPTH;
`endif
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int lane = 0; lane < 4; lane++)
          if (be[lane]) model_mem[word][8*lane +: 8] = wdata[8*lane +: 8];
      end else begin
        rdata = model_mem[word];
      end
    end
  endfunction

  task automatic wait_grant();
    int waited = 0;
    @(negedge clock);
    while (!data_gnt_o && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("gnt_wait", 32'(data_gnt_o), 32'd1);
  endtask

  task automatic apply_request(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit junk,
                               output logic [31:0] act_rdata, output logic act_err,
                               output logic [31:0] exp_rdata, output logic exp_err);
    wait_grant();
    data_addr_valid_i = 1'b1;
    data_we_i         = we;
    data_be_i         = be;
    data_addr_i       = addr;
    data_wdata_i      = wdata;
    @(posedge clock);
    #1;
    model_apply(we, be, addr, wdata, exp_rdata, exp_err);
    // Optionally keep a bogus store pending while busy; it must be ignored.
    if (junk) begin
      data_we_i    = 1'b1;
      data_be_i    = 4'hF;
      data_addr_i  = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      data_wdata_i = $urandom();
    end else begin
      data_addr_valid_i = 1'b0;
    end
    act_rdata = 32'd0;
    act_err   = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clock);
      check("gnt_low", 32'(data_gnt_o), 32'd0);
      check("rvalid_slot", 32'(data_rvalid_o), 32'(j == LAT - 1));
      if (j == LAT - 1) begin
        act_rdata = data_rdata_o;
        act_err   = data_err_o;
      end
    end
    @(negedge clock);
    check("gnt_back", 32'(data_gnt_o), 32'd1);
    check("rvalid_drop", 32'(data_rvalid_o), 32'd0);
    data_addr_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ar, er;
    logic        ae, ee;
    logic [31:0] b2b_addr [3];
    logic [31:0] exp_q [$];
    int          rsp_cyc [4];
    logic [31:0] rsp_data [4];
    int          n_acc, n_rsp;
    bit          acc, seen;

    vecs[0] = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 32'h00, 32'h00000055, 32'h0, 1'b0};
`ifdef DMEM_ERR_CHECK_EN
    vecs[6] = '{1'b0, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1};
    vecs[7] = '{1'b1, 4'hF, 32'(DEPTH * 4), 32'hCAFEF00D, 32'h0, 1'b1};
    vecs[8] = '{1'b0, 4'h0, 32'h00, 32'h0, 32'h00000055, 1'b0};
`else
    vecs[6] = '{1'b0, 4'h0, 32'h22, 32'h0, 32'h11BB33DD, 1'b0};
    vecs[7] = '{1'b1, 4'hF, 32'(DEPTH * 4), 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[8] = '{1'b0, 4'h0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0};
`endif

    for (int w = 0; w < DEPTH; w++) model_mem[w] = 'x;
    reset             = 1'b0;
    data_addr_valid_i = 1'b0;
    data_we_i         = 1'b0;
    data_be_i         = 4'h0;
    data_addr_i       = 32'd0;
    data_wdata_i      = 32'd0;

    repeat (2) @(negedge clock);
    check("rst_gnt", 32'(data_gnt_o), 32'd0);
    check("rst_rvalid", 32'(data_rvalid_o), 32'd0);
    check("rst_rdata", data_rdata_o, 32'd0);
    check("rst_err", 32'(data_err_o), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("gnt_after_reset", 32'(data_gnt_o), 32'd1);

    for (int i = 0; i < NV; i++) begin
      apply_request(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 1'b0, ar, ae, er, ee);
      check($sformatf("vec%0d_rdata", i), ar, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(ae), 32'(vecs[i].exp_err));
    end

    // Store pending when reset hits: response dropped, write kept.
    wait_grant();
    data_addr_valid_i = 1'b1;
    data_we_i         = 1'b1;
    data_be_i         = 4'hF;
    data_addr_i       = 32'h0C;
    data_wdata_i      = 32'h5A5AA5A5;
    @(posedge clock);
    #1 data_addr_valid_i = 1'b0;
    model_apply(1'b1, 4'hF, 32'h0C, 32'h5A5AA5A5, er, ee);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_gnt", 32'(data_gnt_o), 32'd0);
    check("midrst_rvalid", 32'(data_rvalid_o), 32'd0);
    check("midrst_rdata", data_rdata_o, 32'd0);
    check("midrst_err", 32'(data_err_o), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_gnt_release", 32'(data_gnt_o), 32'd1);
    seen = 1'b0;
    for (int j = 0; j < LAT + 2; j++) begin
      @(negedge clock);
      if (data_rvalid_o) seen = 1'b1;
    end
    check("midrst_no_rvalid", 32'(seen), 32'd0);
    apply_request(1'b0, 4'h0, 32'h0C, 32'h0, 1'b0, ar, ae, er, ee);
    check("midrst_store_kept", ar, 32'h5A5AA5A5);

    for (int w = 0; w < DEPTH; w++) begin
      apply_request(1'b1, 4'hF, 32'(w * 4), $urandom(), 1'b0, ar, ae, er, ee);
      check("fill_rdata", ar, er);
      check("fill_err", 32'(ae), 32'(ee));
    end

    // Valid held high for three loads: responses LAT+1 apart, in request order.
    b2b_addr[0] = 32'h10;
    b2b_addr[1] = 32'h20;
    b2b_addr[2] = 32'h04;
    wait_grant();
    data_addr_valid_i = 1'b1;
    data_we_i         = 1'b0;
    data_be_i         = 4'h0;
    data_addr_i       = b2b_addr[0];
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 6 * (LAT + 1) && n_rsp < 4; c++) begin
      acc = data_gnt_o && data_addr_valid_i;
      @(posedge clock);
      #1;
      if (acc) begin
        model_apply(1'b0, 4'h0, data_addr_i, 32'h0, er, ee);
        exp_q.push_back(er);
        n_acc++;
        if (n_acc < 3) data_addr_i = b2b_addr[n_acc];
        else data_addr_valid_i = 1'b0;
      end
      @(negedge clock);
      if (data_rvalid_o) begin
        rsp_cyc[n_rsp]  = c;
        rsp_data[n_rsp] = data_rdata_o;
        n_rsp++;
      end
    end
    data_addr_valid_i = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_responses", 32'(n_rsp), 32'd3);
    if (n_rsp >= 3 && exp_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("b2b_data%0d", i), rsp_data[i], exp_q[i]);
      check("b2b_spacing01", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'(LAT + 1));
      check("b2b_spacing12", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'(LAT + 1));
    end

    for (int n = 0; n < 150; n++) begin
      logic [31:0] addr;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom();
      else addr = 32'($urandom_range(0, DEPTH + 1)) * 32'd4 + ((r == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
      apply_request(1'(($urandom() & 1)), 4'($urandom()), addr, $urandom(),
                    ($urandom_range(0, 3) == 0), ar, ae, er, ee);
      check("rand_rdata", ar, er);
      check("rand_err", 32'(ae), 32'(ee));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
